// File: rtl/tree_adder_procedural.sv
// tree_adder_procedural: two-stage registered adder tree, sum3 = (a+b) + (c+d) at full width.
// Stage 1 registers a+b and c+d; stage 2 registers their sum one cycle later.
module tree_adder_procedural #(
    parameter int AW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic [CW-1:0] c,
    input  logic [CW-1:0] d,
    output logic [AW:0]   sum1,
    output logic [CW:0]   sum2,
    output logic          sum12_valid,
    output logic [CW+1:0] sum3,
    output logic          sum3_valid
);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sum1        <= '0;
            sum2        <= '0;
            sum12_valid <= 1'b0;
            sum3        <= '0;
            sum3_valid  <= 1'b0;
        end else begin
            if (in_valid) begin
                sum1 <= {1'b0, a} + {1'b0, b};
                sum2 <= {1'b0, c} + {1'b0, d};
            end
            sum12_valid <= in_valid;
            // stage 2 consumes the stage-1 registers, so it trails by exactly one edge
            if (sum12_valid)
                sum3 <= {{(CW+1-AW){1'b0}}, sum1} + {1'b0, sum2};
            sum3_valid <= sum12_valid;
        end
endmodule

// File: tb/tb_tree_adder_procedural.sv
// tb_tree_adder_procedural: directed checks of reset, pipeline latency, max values, bubbles and mid-stream reset.
module tb_tree_adder_procedural;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] a, b;
    logic [7:0] c, d;
    logic [4:0] sum1;
    logic [8:0] sum2;
    logic       sum12_valid;
    logic [9:0] sum3;
    logic       sum3_valid;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit v;
        int a, b, c, d, s1, s2, s3;
    } vec_t;

    vec_t vecs[10] = '{
        '{1, 0, 3, 1, 255, 3, 256, 259},
        '{1, 10, 13, 9, 10, 23, 19, 42},
        '{1, 15, 15, 109, 37, 30, 146, 176},
        '{1, 0, 9, 45, 45, 9, 90, 99},
        '{1, 15, 15, 255, 255, 30, 510, 540},
        '{1, 1, 2, 3, 4, 3, 7, 10},
        '{0, 7, 7, 7, 7, 14, 14, 28},
        '{1, 5, 6, 100, 200, 11, 300, 311},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0}
    };

    tree_adder_procedural #(.AW(4), .CW(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d),
        .sum1(sum1), .sum2(sum2), .sum12_valid(sum12_valid),
        .sum3(sum3), .sum3_valid(sum3_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".sum1"}, 16'(sum1), 16'd0);
        check({tag, ".sum2"}, 16'(sum2), 16'd0);
        check({tag, ".sum3"}, 16'(sum3), 16'd0);
        check({tag, ".v12"}, 16'(sum12_valid), 16'd0);
        check({tag, ".v3"}, 16'(sum3_valid), 16'd0);
    endtask

    task automatic drive(input bit v, input int ia, input int ib, input int ic, input int id);
        @(negedge clk);
        in_valid = v;
        a = 4'(ia);
        b = 4'(ib);
        c = 8'(ic);
        d = 8'(id);
    endtask

    int e1 = 0, e2 = 0, e3 = 0, li = 0;
    bit e12v = 0, e3v = 0;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        #2;
        check_zero("rst_init");
        drive(1, 15, 15, 255, 255);
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_held");
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            @(posedge clk);
            #1;
            if (e12v) e3 = vecs[li].s3;
            e3v = e12v;
            if (vecs[i].v) begin
                e1 = vecs[i].s1;
                e2 = vecs[i].s2;
                li = i;
            end
            e12v = vecs[i].v;
            check($sformatf("v%0d.sum1", i), 16'(sum1), 16'(e1));
            check($sformatf("v%0d.sum2", i), 16'(sum2), 16'(e2));
            check($sformatf("v%0d.v12", i), 16'(sum12_valid), 16'(e12v));
            check($sformatf("v%0d.sum3", i), 16'(sum3), 16'(e3));
            check($sformatf("v%0d.v3", i), 16'(sum3_valid), 16'(e3v));
        end
        drive(1, 10, 13, 9, 10);
        drive(1, 15, 15, 109, 37);
        @(posedge clk);
        #1;
        check("mid.v12_before", 16'(sum12_valid), 16'd1);
        check("mid.v3_before", 16'(sum3_valid), 16'd1);
        check("mid.sum3_before", 16'(sum3), 16'd42);
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_rst");
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("post_rst");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
